// File: rtl/usb_pkg.sv
// Shared definitions for the FX3 slave-FIFO engines and the mode scheduler:
// master_mode codes, scheduler states and the stream-in engine idle code.
package usb_pkg;

  localparam logic [2:0] MODE_IDLE       = 3'b101;
  localparam logic [2:0] MODE_STREAM_IN  = 3'b010;
  localparam logic [2:0] MODE_STREAM_OUT = 3'b011;

  localparam logic [1:0] STREAM_IN_IDLE_CODE = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT_IN  = 3'd1,
    S_GRANT_OUT = 3'd2,
    S_DRAIN_IN  = 3'd3,
    S_DRAIN_OUT = 3'd4,
    S_TURN      = 3'd5
  } sched_state_e;

  typedef enum logic {
    SIDE_IN  = 1'b0,
    SIDE_OUT = 1'b1
  } side_e;

  // Only the two grant states ever put a stream mode on the bus.
  function automatic logic [2:0] mode_of(input sched_state_e s);
    case (s)
      S_GRANT_IN:  mode_of = MODE_STREAM_IN;
      S_GRANT_OUT: mode_of = MODE_STREAM_OUT;
      default:     mode_of = MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/usb_mode_scheduler.sv
// Round-robin time-sharing of the FX3 slave-FIFO bus between stream-in and
// stream-out, with per-grant quantum, engine drain and bus turnaround gap.
module usb_mode_scheduler
  import usb_pkg::*;
#(
  parameter int unsigned QUANTUM    = 64,
  parameter int unsigned TURNAROUND = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        in_req,
  input  logic        out_req,
  input  logic        in_idle,
  input  logic        out_idle,
  output logic [2:0]  master_mode,
  output logic        grant_in,
  output logic        grant_out,
  output logic        busy,
  output logic [15:0] switch_count
);

  localparam logic [15:0] Q_MAX  = 16'(QUANTUM);
  localparam logic [15:0] Q_LAST = 16'(QUANTUM - 1);
  localparam logic [3:0]  T_LAST = 4'(TURNAROUND - 1);

  sched_state_e r_state;
  sched_state_e w_next;
  side_e        r_last_grant;
  logic [15:0]  r_qcnt;
  logic [3:0]   r_tcnt;
  logic [2:0]   r_master_mode;
  logic         r_grant_in;
  logic         r_grant_out;
  logic         r_busy;
  logic [15:0]  r_switch_count;
  logic         w_quantum_done;

  // >= rather than == so a saturated grant still yields once the peer asks.
  assign w_quantum_done = (r_qcnt >= Q_LAST);

  // Next-state selection; outputs are registered from this value below.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable && in_req && (!out_req || (r_last_grant == SIDE_OUT))) begin
          w_next = S_GRANT_IN;
        end else if (enable && out_req) begin
          w_next = S_GRANT_OUT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_GRANT_IN: begin
        if (!in_req || !enable || (w_quantum_done && out_req)) begin
          w_next = S_DRAIN_IN;
        end else begin
          w_next = S_GRANT_IN;
        end
      end
      S_GRANT_OUT: begin
        if (!out_req || !enable || (w_quantum_done && in_req)) begin
          w_next = S_DRAIN_OUT;
        end else begin
          w_next = S_GRANT_OUT;
        end
      end
      S_DRAIN_IN: begin
        if (in_idle) begin
          w_next = S_TURN;
        end else begin
          w_next = S_DRAIN_IN;
        end
      end
      S_DRAIN_OUT: begin
        if (out_idle) begin
          w_next = S_TURN;
        end else begin
          w_next = S_DRAIN_OUT;
        end
      end
      S_TURN: begin
        if (r_tcnt == T_LAST) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_TURN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, counters and outputs all decoded from the next state on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_last_grant   <= SIDE_OUT;
      r_qcnt         <= 16'd0;
      r_tcnt         <= 4'd0;
      r_master_mode  <= MODE_IDLE;
      r_grant_in     <= 1'b0;
      r_grant_out    <= 1'b0;
      r_busy         <= 1'b0;
      r_switch_count <= 16'd0;
    end else begin
      r_state       <= w_next;
      r_master_mode <= mode_of(w_next);
      r_grant_in    <= (w_next == S_GRANT_IN);
      r_grant_out   <= (w_next == S_GRANT_OUT);
      r_busy        <= (w_next != S_IDLE);

      if ((r_state == S_IDLE) && (w_next == S_GRANT_IN)) begin
        r_qcnt       <= 16'd0;
        r_last_grant <= SIDE_IN;
      end else if ((r_state == S_IDLE) && (w_next == S_GRANT_OUT)) begin
        r_qcnt       <= 16'd0;
        r_last_grant <= SIDE_OUT;
      end else if (((r_state == S_GRANT_IN) || (r_state == S_GRANT_OUT)) && (r_qcnt != Q_MAX)) begin
        r_qcnt <= r_qcnt + 16'd1;
      end else begin
        r_qcnt <= r_qcnt;
      end

      if ((r_state != S_TURN) && (w_next == S_TURN)) begin
        r_tcnt         <= 4'd0;
        r_switch_count <= r_switch_count + 16'd1;
      end else if (r_state == S_TURN) begin
        r_tcnt <= r_tcnt + 4'd1;
      end else begin
        r_tcnt <= r_tcnt;
      end
    end
  end

  assign master_mode  = r_master_mode;
  assign grant_in     = r_grant_in;
  assign grant_out    = r_grant_out;
  assign busy         = r_busy;
  assign switch_count = r_switch_count;

endmodule

// File: tb/tb_usb_mode_scheduler.sv
// Directed bench for usb_mode_scheduler with QUANTUM=8, TURNAROUND=2.
module tb_usb_mode_scheduler;

  localparam logic [2:0] M_IDLE = 3'b101;
  localparam logic [2:0] M_IN   = 3'b010;
  localparam logic [2:0] M_OUT  = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n, enable, in_req, out_req, in_idle, out_idle;
  logic [2:0]  master_mode;
  logic        grant_in, grant_out, busy;
  logic [15:0] switch_count;

  int checks = 0;
  int errors = 0;

  usb_mode_scheduler #(.QUANTUM(8), .TURNAROUND(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_req(in_req), .out_req(out_req),
    .in_idle(in_idle), .out_idle(out_idle), .master_mode(master_mode),
    .grant_in(grant_in), .grant_out(grant_out), .busy(busy), .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample on the falling edge; grants must never overlap.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("grant_excl", {31'd0, grant_in & grant_out}, 32'd0);
  endtask

  task automatic expect_out(input string tag, input logic [2:0] m, input logic gi,
                            input logic go, input logic b);
    chk({tag, "_mode"}, {29'd0, master_mode}, {29'd0, m});
    chk({tag, "_gin"},  {31'd0, grant_in},    {31'd0, gi});
    chk({tag, "_gout"}, {31'd0, grant_out},   {31'd0, go});
    chk({tag, "_busy"}, {31'd0, busy},        {31'd0, b});
  endtask

  task automatic expect_sc(input string tag, input logic [15:0] sc);
    chk(tag, {16'd0, switch_count}, {16'd0, sc});
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; in_req = 1'b1; out_req = 1'b0;
    in_idle = 1'b1; out_idle = 1'b1;

    // Reset held two cycles with a pending request.
    tick(); tick();
    expect_out("reset", M_IDLE, 1'b0, 1'b0, 1'b0);
    expect_sc("reset_sc", 16'd0);
    rst_n = 1'b1;
    tick();
    expect_out("first_grant", M_IN, 1'b1, 1'b0, 1'b1);

    // Lone requester keeps the bus well beyond the quantum.
    for (int i = 2; i <= 20; i++) begin
      tick();
      expect_out("solo_in", M_IN, 1'b1, 1'b0, 1'b1);
    end
    in_req = 1'b0;
    tick(); expect_out("solo_drain", M_IDLE, 1'b0, 1'b0, 1'b1); expect_sc("solo_drain_sc", 16'd0);
    tick(); expect_out("solo_turn1", M_IDLE, 1'b0, 1'b0, 1'b1); expect_sc("solo_turn_sc", 16'd1);
    tick(); expect_out("solo_turn2", M_IDLE, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("solo_idle", M_IDLE, 1'b0, 1'b0, 1'b0);

    // Dual requests: last grant was IN, so OUT goes first for a full quantum.
    in_req = 1'b1; out_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); expect_out("rr_out", M_OUT, 1'b0, 1'b1, 1'b1);
    end
    tick(); expect_out("rr_drain", M_IDLE, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("rr_turn1", M_IDLE, 1'b0, 1'b0, 1'b1); expect_sc("rr_sc", 16'd2);
    tick(); expect_out("rr_turn2", M_IDLE, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("rr_idle", M_IDLE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(); expect_out("rr_in", M_IN, 1'b1, 1'b0, 1'b1);
    end

    // Stream-in engine slow to finish its packet at quantum expiry.
    in_idle = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); expect_out("slow_drain", M_IDLE, 1'b0, 1'b0, 1'b1); expect_sc("slow_drain_sc", 16'd2);
    end
    in_idle = 1'b1;
    tick(); expect_out("slow_turn1", M_IDLE, 1'b0, 1'b0, 1'b1); expect_sc("slow_sc", 16'd3);
    tick(); expect_out("slow_turn2", M_IDLE, 1'b0, 1'b0, 1'b1); expect_sc("slow_sc_once", 16'd3);
    tick(); expect_out("slow_idle", M_IDLE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out("en_out", M_OUT, 1'b0, 1'b1, 1'b1);
    end

    // Enable dropped with qcnt=3.
    enable = 1'b0;
    tick(); expect_out("en_drain", M_IDLE, 1'b0, 1'b0, 1'b1);
    tick(); expect_sc("en_sc", 16'd4);
    tick(); tick(); expect_out("en_idle", M_IDLE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("en_hold", M_IDLE, 1'b0, 1'b0, 1'b0);
    end
    enable = 1'b1;
    tick(); expect_out("en_regrant", M_IN, 1'b1, 1'b0, 1'b1);

    // Reach S_DRAIN_OUT, then reset there.
    in_req = 1'b0;
    tick(); expect_out("mr_drain_in", M_IDLE, 1'b0, 1'b0, 1'b1);
    tick(); expect_sc("mr_sc", 16'd5);
    tick(); tick();
    tick(); expect_out("mr_out", M_OUT, 1'b0, 1'b1, 1'b1);
    out_idle = 1'b0; out_req = 1'b0;
    tick(); expect_out("mr_drain_out", M_IDLE, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("mr_drain_hold", M_IDLE, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick(); expect_out("mr_reset", M_IDLE, 1'b0, 1'b0, 1'b0); expect_sc("mr_reset_sc", 16'd0);
    rst_n = 1'b1; in_req = 1'b1; out_req = 1'b1; out_idle = 1'b1;
    tick(); expect_out("mr_tie_in", M_IN, 1'b1, 1'b0, 1'b1);

    // Counter wrap: preload near the top, then complete two grants.
    in_req = 1'b0; out_req = 1'b0;
    tick(); tick(); expect_sc("wrap_pre", 16'd1);
    tick(); tick(); expect_out("wrap_idle", M_IDLE, 1'b0, 1'b0, 1'b0);
    force dut.r_switch_count = 16'hFFFE;
    #1;
    release dut.r_switch_count;
    in_req = 1'b1;
    tick(); expect_out("wrap_g1", M_IN, 1'b1, 1'b0, 1'b1);
    in_req = 1'b0;
    tick(); tick(); expect_sc("wrap_ffff", 16'hFFFF);
    tick(); tick();
    in_req = 1'b1;
    tick();
    in_req = 1'b0;
    tick(); tick(); expect_sc("wrap_zero", 16'h0000);
    tick(); tick(); expect_out("wrap_end", M_IDLE, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_mode_scheduler.md
Name: usb_mode_scheduler

Overview:
- Time-shares the FX3 slave-FIFO bus between the host-bound stream-in engine (usb_stream_in) and the host-to-FPGA stream-out engine.
- Drives the 3-bit master_mode word consumed by both engines, using round-robin arbitration with a per-grant cycle quantum.
- Guarantees that an engine has returned to idle, and that a bus turnaround gap has elapsed, before the other engine is granted.
- Sits between the application-side FIFOs/status and the two USB engines.

Parameters:
- QUANTUM, 64: maximum grant length in clk cycles while the other side is requesting; legal range 1..65535.
- TURNAROUND, 2: idle cycles held between a drain completing and the next grant, covering the DQ direction and SLOE change; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- enable  in  1  scheduler enable; when low, no new grant and any active grant is drained.
- in_req  in  1  stream-in wants the bus (source FIFO at or above threshold).
- out_req  in  1  stream-out wants the bus (FX3 has host data).
- in_idle  in  1  stream-in engine is in its idle state (current_stream_in_mode == 2'b00).
- out_idle  in  1  stream-out engine is in its idle state.
- master_mode  out  3  mode word to both engines: MODE_IDLE, MODE_STREAM_IN or MODE_STREAM_OUT.
- grant_in  out  1  stream-in currently granted.
- grant_out  out  1  stream-out currently granted.
- busy  out  1  state is not S_IDLE.
- switch_count  out  16  number of completed grants; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset
  - Clock is clk. Reset is rst_n: synchronous, active-low, sampled on the clk rising edge.
  - Reset values: master_mode = MODE_IDLE (3'b101), grant_in = 0, grant_out = 0, busy = 0, switch_count = 0, state = S_IDLE, qcnt = 0, last_grant = OUT (so IN wins the first tie).
  - Reset mid-grant returns everything to reset values on that edge. There is no drain.
- Outputs
  - All outputs are registered and decoded from the current state.
  - Latency from a request to master_mode changing is 1 cycle.
- States
  - S_IDLE
    - If enable is low, or neither request is high: stay.
    - One request high: go to S_GRANT_IN or S_GRANT_OUT.
    - Both requests high: grant the side opposite last_grant.
    - On entry to a grant: qcnt = 0; last_grant = that side.
  - S_GRANT_IN / S_GRANT_OUT
    - Outputs: master_mode = MODE_STREAM_IN or MODE_STREAM_OUT; the matching grant_* = 1.
    - qcnt increments every cycle and saturates at QUANTUM.
    - Exit to S_DRAIN_x when any of these is true:
      - own request is low;
      - enable is low;
      - qcnt == QUANTUM-1 and the other side's request is high.
    - Quantum expiry with the other side not requesting: stay, keep qcnt saturated, no needless switch.
    - Quantum expiry and own request drop in the same cycle: single transition to drain.
  - S_DRAIN_IN / S_DRAIN_OUT
    - Outputs: master_mode = MODE_IDLE; grants = 0.
    - Wait for the matching *_idle = 1, then go to S_TURN and increment switch_count.
    - Minimum residency is 1 cycle, even if *_idle is already high on entry.
    - No timeout: the engine must finish its packet end.
  - S_TURN
    - Outputs: master_mode = MODE_IDLE.
    - tcnt counts TURNAROUND cycles, then the state returns to S_IDLE.
    - Requests are ignored during S_TURN.
- Invariants
  - grant_in and grant_out are never both 1.
  - No cycle has master_mode != MODE_IDLE while in S_DRAIN_x or S_TURN.
- Fairness: under continuous dual requests, grants alternate IN, OUT, IN, ... Each grant lasts exactly QUANTUM cycles of STREAM mode.

Decomposition:
- Package usb_pkg holds:
  - MODE_IDLE = 3'b101, MODE_STREAM_IN = 3'b010, MODE_STREAM_OUT = 3'b011;
  - the state enum (S_IDLE, S_GRANT_IN, S_GRANT_OUT, S_DRAIN_IN, S_DRAIN_OUT, S_TURN);
  - the stream-in engine idle code 2'b00.
- The engines share usb_pkg.
- The block is a single module with no sub-module; the quantum and turnaround counters are inline.

Test Plan (QUANTUM=8, TURNAROUND=2):
- Reset: rst_n low for 2 cycles with in_req=1 -> master_mode=3'b101, grants 0, switch_count 0. Deassert -> next edge master_mode=3'b010, grant_in=1.
- Single requester: in_req=1 held for 20 cycles, out_req=0 -> STREAM_IN for all 20 cycles, no drain. Drop in_req, hold in_idle=1 -> DRAIN 1 cycle, TURN 2 cycles, S_IDLE, switch_count=1.
- Quantum arbitration: in_req=out_req=1 continuous, idle inputs 1 -> 8 cycles STREAM_IN, 1 DRAIN, 2 TURN, 1 IDLE, 8 cycles STREAM_OUT, ...; grants alternate and are never overlapping.
- Slow drain: at the IN quantum expiry, hold in_idle=0 for 5 cycles -> master_mode stays 3'b101 and grant_out stays 0 until in_idle=1. TURN then starts and switch_count increments once.
- enable drop: enable=0 mid-grant at qcnt=3 -> next edge DRAIN, no new grant while enable=0. Re-enable with both requests high -> the side opposite last_grant is granted.
- Mid-operation reset and counter wrap: rst_n=0 during S_DRAIN_OUT -> next edge S_IDLE, outputs at reset values. Force 65536 completed grants -> switch_count wraps to 0.
